// File: rtl/core_pipe_exec_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : core_pipe_exec_alu_seq
// Purpose  : Handshaked integer ALU for the execute stage. Add/sub/logic/
//            compare complete in one cycle with a registered result. Shifts
//            run iteratively, SHIFT_STEP bits per cycle. A synchronous flush
//            aborts any operation in flight.
// Config   : `define CORE_ALU_FAST_SHIFT_EN to replace the iterative shifter
//            with a single-cycle log-stage barrel shifter. The SHIFT state is
//            then never entered and every op has 1-cycle latency.
// Ports    : g_clk, g_resetn (async, active-low), flush
//            req_valid/req_ready, req_opr_a, req_opr_b, req_word, req_op[9:0]
//              req_op one-hot: 0 add 1 sub 2 xor 3 or 4 and 5 slt 6 sltu
//                              7 srl 8 sll 9 sra
//            rsp_valid/rsp_ready, rsp_result, rsp_cmp_eq, rsp_cmp_lt
//            busy (state != IDLE)
// Revision : 1.0 - initial release
// ============================================================================
module core_pipe_exec_alu_seq #(
  parameter int XLEN       = 64,
  parameter int SHIFT_STEP = 8
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_opr_a,
  input  logic [XLEN-1:0] req_opr_b,
  input  logic            req_word,
  input  logic [9:0]      req_op,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_result,
  output logic            rsp_cmp_eq,
  output logic            rsp_cmp_lt,
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            cmp_eq_q, cmp_eq_d;
  logic            cmp_lt_q, cmp_lt_d;

  // Sign-extend from bit 31 when w is set, otherwise pass through.
  function automatic logic [XLEN-1:0] sext_word(input logic [XLEN-1:0] v, input logic w);
    logic signed [XLEN-1:0] t;
    t = $signed(v[31:0]);
    return w ? t : v;
  endfunction

  // Arithmetic right shift done on a signed temporary so the shift operand
  // cannot lose its signedness through expression context.
  function automatic logic [XLEN-1:0] sra_f(input logic [XLEN-1:0] v, input logic [SHW:0] n);
    logic signed [XLEN-1:0] s;
    s = $signed(v);
    s = s >>> n;
    return s;
  endfunction

  // --------------------------------------------------------------------------
  // Request decode and single-cycle datapath
  // --------------------------------------------------------------------------
  logic            word;
  logic            is_shift;
  logic            op_sub;
  logic            accept;
  logic [XLEN-1:0] opr_bx;
  logic [XLEN-1:0] sum;
  logic            carry;
  logic            lt_s, lt_u, lt_sw, lt_uw;
  logic            cmp_lt, cmp_eq;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] sh_src;
  logic [SHW-1:0]  sh_amt;

  assign word     = (XLEN == 64) && req_word;
  assign is_shift = |req_op[9:7];
  // Compares reuse the adder as a subtractor.
  assign op_sub   = req_op[1] | req_op[5] | req_op[6];
  assign opr_bx   = op_sub ? ~req_opr_b : req_opr_b;
  assign {carry, sum} = {1'b0, req_opr_a} + {1'b0, opr_bx} + {{XLEN{1'b0}}, op_sub};

  assign lt_u = ~carry;
  assign lt_s = (req_opr_a[XLEN-1] ^ req_opr_b[XLEN-1]) ? req_opr_a[XLEN-1] : sum[XLEN-1];

  generate
    if (XLEN > 32) begin : g_word_cmp
      // Carry out of bit 31 recovered from bit 32 of the full-width sum.
      logic carry32;
      assign carry32 = sum[32] ^ req_opr_a[32] ^ opr_bx[32];
      assign lt_uw   = ~carry32;
      assign lt_sw   = (req_opr_a[31] ^ req_opr_b[31]) ? req_opr_a[31] : sum[31];
    end else begin : g_no_word_cmp
      assign lt_uw = lt_u;
      assign lt_sw = lt_s;
    end
  endgenerate

  assign cmp_lt = (req_op[5] & (word ? lt_sw : lt_s)) |
                  (req_op[6] & (word ? lt_uw : lt_u));
  assign cmp_eq = (req_opr_a == req_opr_b);

  assign alu_res = ({XLEN{req_op[0] | req_op[1]}} & sext_word(sum, word))
                 | ({XLEN{req_op[2]}} & (req_opr_a ^ req_opr_b))
                 | ({XLEN{req_op[3]}} & (req_opr_a | req_opr_b))
                 | ({XLEN{req_op[4]}} & (req_opr_a & req_opr_b))
                 | ({XLEN{req_op[5] | req_op[6]}} & XLEN'(cmp_lt));

  // Word shifts work on the low half: sraw fills from bit 31, srlw/sllw
  // see zeros above it. The final sign-extension fixes the upper half.
  assign sh_src = word ? (req_op[9] ? sext_word(req_opr_a, 1'b1) : XLEN'(req_opr_a[31:0]))
                       : req_opr_a;
  assign sh_amt = word ? SHW'(req_opr_b[4:0]) : req_opr_b[SHW-1:0];

  assign accept = req_valid & req_ready;

`ifdef CORE_ALU_FAST_SHIFT_EN
  // --------------------------------------------------------------------------
  // Single-cycle barrel shifter: stage i shifts by 2^i when sh_amt[i] is set.
  // --------------------------------------------------------------------------
  logic [XLEN-1:0] bs [SHW+1];
  logic [XLEN-1:0] shift_res;

  assign bs[0] = sh_src;
  for (genvar i = 0; i < SHW; i++) begin : g_bstage
    localparam int AMT = 1 << i;
    assign bs[i+1] = !sh_amt[i] ? bs[i]
                   : req_op[8]  ? (bs[i] << AMT)
                   : req_op[9]  ? sra_f(bs[i], AMT[SHW:0])
                   :              (bs[i] >> AMT);
  end
  assign shift_res = sext_word(bs[SHW], word);
`else
  // --------------------------------------------------------------------------
  // Iterative shifter: up to SHIFT_STEP bits per cycle.
  // --------------------------------------------------------------------------
  localparam logic [SHW:0] STEP = SHIFT_STEP[SHW:0];

  logic [XLEN-1:0] sh_q, sh_d, sh_next;
  logic [SHW:0]    rem_q, rem_d, rem_next, step;
  logic            left_q, left_d;
  logic            arith_q, arith_d;
  logic            word_q, word_d;

  assign step     = (rem_q >= STEP) ? STEP : rem_q;
  assign rem_next = rem_q - step;
  assign sh_next  = left_q  ? (sh_q << step)
                  : arith_q ? sra_f(sh_q, step)
                  :           (sh_q >> step);
`endif

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      cmp_eq_q <= 1'b0;
      cmp_lt_q <= 1'b0;
`ifdef CORE_ALU_FAST_SHIFT_EN
`else
      sh_q     <= '0;
      rem_q    <= '0;
      left_q   <= 1'b0;
      arith_q  <= 1'b0;
      word_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      cmp_eq_q <= cmp_eq_d;
      cmp_lt_q <= cmp_lt_d;
`ifdef CORE_ALU_FAST_SHIFT_EN
`else
      sh_q     <= sh_d;
      rem_q    <= rem_d;
      left_q   <= left_d;
      arith_q  <= arith_d;
      word_q   <= word_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath update
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    cmp_eq_d = cmp_eq_q;
    cmp_lt_d = cmp_lt_q;
`ifdef CORE_ALU_FAST_SHIFT_EN
`else
    sh_d     = sh_q;
    rem_d    = rem_q;
    left_d   = left_q;
    arith_d  = arith_q;
    word_d   = word_q;
`endif

    if (flush) begin
      // Flush wins over everything, including a request accepted this cycle.
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: ;
`ifdef CORE_ALU_FAST_SHIFT_EN
`else
        ST_SHIFT: begin
          sh_d  = sh_next;
          rem_d = rem_next;
          if (rem_next == '0) begin
            state_d  = ST_DONE;
            result_d = sext_word(sh_next, word_q);
          end
        end
`endif
        ST_DONE: begin
          if (rsp_ready) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase

      // A new request (from IDLE, or back-to-back from DONE) overrides the
      // transition chosen above.
      if (accept) begin
        cmp_eq_d = cmp_eq;
        cmp_lt_d = cmp_lt;
`ifdef CORE_ALU_FAST_SHIFT_EN
        state_d  = ST_DONE;
        result_d = alu_res | ({XLEN{is_shift}} & shift_res);
`else
        if (is_shift && (sh_amt != '0)) begin
          state_d = ST_SHIFT;
          sh_d    = sh_src;
          rem_d   = {1'b0, sh_amt};
          left_d  = req_op[8];
          arith_d = req_op[9];
          word_d  = word;
        end else begin
          state_d  = ST_DONE;
          result_d = alu_res | ({XLEN{is_shift}} & sext_word(sh_src, word));
        end
`endif
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      ST_DONE: begin
        rsp_valid = 1'b1;
        req_ready = rsp_ready;
      end
      default: ;
    endcase
  end

  assign rsp_result = result_q;
  assign rsp_cmp_eq = cmp_eq_q;
  assign rsp_cmp_lt = cmp_lt_q;

endmodule
`default_nettype wire

// File: tb/tb_core_pipe_exec_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_pipe_exec_alu_seq
// Purpose  : Scoreboard bench for core_pipe_exec_alu_seq (XLEN=64, STEP=8).
//            A driver issues directed vectors and pushes hand-computed
//            results; a monitor pops and compares on each rsp handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_core_pipe_exec_alu_seq;

  localparam int XLEN       = 64;
  localparam int SHIFT_STEP = 8;

  localparam logic [9:0] OP_ADD  = 10'd1;
  localparam logic [9:0] OP_SUB  = 10'd2;
  localparam logic [9:0] OP_XOR  = 10'd4;
  localparam logic [9:0] OP_OR   = 10'd8;
  localparam logic [9:0] OP_AND  = 10'd16;
  localparam logic [9:0] OP_SLT  = 10'd32;
  localparam logic [9:0] OP_SLTU = 10'd64;
  localparam logic [9:0] OP_SRL  = 10'd128;
  localparam logic [9:0] OP_SLL  = 10'd256;
  localparam logic [9:0] OP_SRA  = 10'd512;

  logic        g_clk     = 1'b0;
  logic        g_resetn  = 1'b0;
  logic        flush     = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_word  = 1'b0;
  logic        rsp_ready = 1'b1;
  logic [63:0] req_opr_a = '0;
  logic [63:0] req_opr_b = '0;
  logic [9:0]  req_op    = '0;
  logic        req_ready, rsp_valid, rsp_cmp_eq, rsp_cmp_lt, busy;
  logic [63:0] rsp_result;

  core_pipe_exec_alu_seq #(
    .XLEN       (XLEN),
    .SHIFT_STEP (SHIFT_STEP)
  ) dut (
    .g_clk      (g_clk),
    .g_resetn   (g_resetn),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opr_a  (req_opr_a),
    .req_opr_b  (req_opr_b),
    .req_word   (req_word),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_cmp_eq (rsp_cmp_eq),
    .rsp_cmp_lt (rsp_cmp_lt),
    .busy       (busy)
  );

  always #5 g_clk = ~g_clk;

  typedef struct {
    logic [63:0] res;
    logic        eq;
    logic        lt;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge g_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  // Expected latency of a shift by amt bits.
  function automatic int shift_lat(input int amt);
`ifdef CORE_ALU_FAST_SHIFT_EN
    return (amt >= 0) ? 1 : 1;
`else
    return 1 + (amt + SHIFT_STEP - 1) / SHIFT_STEP;
`endif
  endfunction

  // Present a request, wait (bounded) for acceptance, push the expectation
  // when chk is set. Called #1 after a rising edge; returns #1 after the
  // accepting edge.
  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic w,
                       input logic [9:0] op, input logic [63:0] er, input logic ee,
                       input logic el, input int elat, input bit chk, output int waited);
    req_valid = 1'b1;
    req_opr_a = a;
    req_opr_b = b;
    req_word  = w;
    req_op    = op;
    waited    = 0;
    @(negedge g_clk);
    while (!req_ready && waited < 100) begin
      waited++;
      @(negedge g_clk);
    end
    if (!req_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: req_ready=0 after %0d cycles, expected 1", waited);
    end else if (chk) begin
      sb_q.push_back('{res: er, eq: ee, lt: el, lat: elat, acc: cyc + 1});
    end
    @(posedge g_clk);
    #1;
    req_valid = 1'b0;
    req_op    = '0;
    req_word  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      @(negedge g_clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", sb_q.size());
      sb_q.delete();
    end
    @(posedge g_clk);
    #1;
  endtask

  // Monitor: latency is measured from the accepting edge to the edge after
  // which rsp_valid first shows this response.
  initial begin : monitor
    bit   in_rsp;
    int   start;
    exp_t e;
    in_rsp = 1'b0;
    start  = 0;
    forever begin
      @(negedge g_clk);
      if (rsp_valid) begin
        if (!in_rsp) begin
          in_rsp = 1'b1;
          start  = cyc;
        end
        if (rsp_ready) begin
          in_rsp = 1'b0;
          if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_rsp: got result 0x%016h with no request outstanding", rsp_result);
          end else begin
            e = sb_q.pop_front();
            check("rsp_result", rsp_result, e.res);
            check("rsp_cmp_eq", 64'(rsp_cmp_eq), 64'(e.eq));
            check("rsp_cmp_lt", 64'(rsp_cmp_lt), 64'(e.lt));
            check("latency", 64'(start - e.acc + 1), 64'(e.lat));
          end
        end
      end else begin
        in_rsp = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int w;
    #1;
    // Reset values while g_resetn is low.
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_rsp_result", rsp_result, 64'd0);
    check("reset_cmp_eq", 64'(rsp_cmp_eq), 64'd0);
    check("reset_cmp_lt", 64'(rsp_cmp_lt), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    @(posedge g_clk); #1;
    g_resetn = 1'b1;
    @(posedge g_clk); #1;

    // Add/sub/logic/compare, word variants and shift boundaries.
    issue(64'h7FFFFFFF, 64'd1, 1'b1, OP_ADD, 64'hFFFFFFFF80000000, 1'b0, 1'b0, 1, 1'b1, w);
    issue(64'd1, 64'hFFFFFFFFFFFFFFFF, 1'b0, OP_SLTU, 64'd1, 1'b0, 1'b1, 1, 1'b1, w);
    issue(64'd1, 64'hFFFFFFFFFFFFFFFF, 1'b0, OP_SLT, 64'd0, 1'b0, 1'b0, 1, 1'b1, w);
    issue(64'd5, 64'd7, 1'b0, OP_SUB, 64'hFFFFFFFFFFFFFFFE, 1'b0, 1'b0, 1, 1'b1, w);
    issue(64'hFFFFFFFFFFFFFFFF, 64'd1, 1'b0, OP_ADD, 64'd0, 1'b0, 1'b0, 1, 1'b1, w);
    issue(64'h1234, 64'h1234, 1'b0, OP_XOR, 64'd0, 1'b1, 1'b0, 1, 1'b1, w);
    issue(64'hF0, 64'h0F, 1'b0, OP_OR, 64'hFF, 1'b0, 1'b0, 1, 1'b1, w);
    issue(64'hFF00FF, 64'h0F0F0F, 1'b0, OP_AND, 64'h0F000F, 1'b0, 1'b0, 1, 1'b1, w);
    issue(64'h00000000FFFFFFFF, 64'd0, 1'b1, OP_SLT, 64'd1, 1'b0, 1'b1, 1, 1'b1, w);
    issue(64'd5, 64'd5, 1'b0, OP_SLTU, 64'd0, 1'b1, 1'b0, 1, 1'b1, w);
    issue(64'h8000000000000000, 64'd63, 1'b0, OP_SRA, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0, shift_lat(63), 1'b1, w);
    issue(64'h80000000, 64'd4, 1'b1, OP_SRA, 64'hFFFFFFFFF8000000, 1'b0, 1'b0, shift_lat(4), 1'b1, w);
    issue(64'h8000000000000000, 64'd63, 1'b0, OP_SRL, 64'd1, 1'b0, 1'b0, shift_lat(63), 1'b1, w);
    issue(64'h8000000000000000, 64'd8, 1'b0, OP_SRA, 64'hFF80000000000000, 1'b0, 1'b0, shift_lat(8), 1'b1, w);
    issue(64'd3, 64'h41, 1'b0, OP_SLL, 64'd6, 1'b0, 1'b0, shift_lat(1), 1'b1, w);
    issue(64'h55, 64'd64, 1'b0, OP_SLL, 64'h55, 1'b0, 1'b0, shift_lat(0), 1'b1, w);
    issue(64'd1, 64'd31, 1'b1, OP_SLL, 64'hFFFFFFFF80000000, 1'b0, 1'b0, shift_lat(31), 1'b1, w);
    issue(64'hFFFFFFFF80000000, 64'd0, 1'b1, OP_SRL, 64'hFFFFFFFF80000000, 1'b0, 1'b0, shift_lat(0), 1'b1, w);
    issue(64'hFFFFFFFF80000000, 64'h24, 1'b1, OP_SRL, 64'h0000000008000000, 1'b0, 1'b0, shift_lat(4), 1'b1, w);
    drain();

    // Backpressure: response held stable, no new request accepted.
    rsp_ready = 1'b0;
    issue(64'hF0F0F0F0F0F0F0F0, 64'hFF00FF00FF00FF00, 1'b0, OP_XOR, 64'h0FF00FF00FF00FF0, 1'b0, 1'b0, 1, 1'b1, w);
    for (int i = 0; i < 5; i++) begin
      @(negedge g_clk);
      check("hold_rsp_valid", 64'(rsp_valid), 64'd1);
      check("hold_rsp_result", rsp_result, 64'h0FF00FF00FF00FF0);
      check("hold_req_ready", 64'(req_ready), 64'd0);
    end
    @(posedge g_clk); #1;
    rsp_ready = 1'b1;
    issue(64'd2, 64'd3, 1'b0, OP_ADD, 64'd5, 1'b0, 1'b0, 1, 1'b1, w);
    check("b2b_accept_wait", 64'(w), 64'd0);
    drain();

    // Flush in the middle of a long shift.
    rsp_ready = 1'b0;
    issue(64'd1, 64'd40, 1'b0, OP_SLL, 64'd0, 1'b0, 1'b0, 0, 1'b0, w);
    @(posedge g_clk); #1;
    flush = 1'b1;
`ifndef CORE_ALU_FAST_SHIFT_EN
    @(negedge g_clk);
    check("preflush_rsp_valid", 64'(rsp_valid), 64'd0);
    check("preflush_busy", 64'(busy), 64'd1);
`endif
    @(posedge g_clk); #1;
    flush = 1'b0;
    @(negedge g_clk);
    check("flush_rsp_valid", 64'(rsp_valid), 64'd0);
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_req_ready", 64'(req_ready), 64'd1);
    @(posedge g_clk); #1;
    rsp_ready = 1'b1;
    // A request presented together with flush is dropped.
    flush     = 1'b1;
    req_valid = 1'b1;
    req_op    = OP_ADD;
    req_opr_a = 64'd7;
    req_opr_b = 64'd8;
    @(posedge g_clk); #1;
    flush     = 1'b0;
    req_valid = 1'b0;
    req_op    = '0;
    @(negedge g_clk);
    check("flush_drop_rsp_valid", 64'(rsp_valid), 64'd0);
    check("flush_drop_busy", 64'(busy), 64'd0);
    @(posedge g_clk); #1;
    issue(64'd2, 64'd3, 1'b0, OP_ADD, 64'd5, 1'b0, 1'b0, 1, 1'b1, w);
    drain();

    // Asynchronous reset in the middle of a shift.
    rsp_ready = 1'b0;
    issue(64'd1, 64'd40, 1'b0, OP_SLL, 64'd0, 1'b0, 1'b0, 0, 1'b0, w);
    @(posedge g_clk); #1;
    g_resetn = 1'b0;
    #1;
    check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("midrst_rsp_result", rsp_result, 64'd0);
    check("midrst_cmp_eq", 64'(rsp_cmp_eq), 64'd0);
    check("midrst_cmp_lt", 64'(rsp_cmp_lt), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    @(posedge g_clk); #1;
    g_resetn  = 1'b1;
    rsp_ready = 1'b1;
    @(negedge g_clk);
    check("postrst_req_ready", 64'(req_ready), 64'd1);
    @(posedge g_clk); #1;
    issue(64'h10, 64'h20, 1'b0, OP_ADD, 64'h30, 1'b0, 1'b0, 1, 1'b1, w);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
